// File: rtl/wb_burst_traffic_checker.sv
// Wishbone B4 burst traffic checker: writes a pattern region in bursts, reads it
// back, compares, and reports mismatch count, first failing address and timeout.
module wb_burst_traffic_checker #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int BLW = 5,
    parameter int NBW = 16,
    parameter int TMO = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start,
    input  logic            mode,
    input  logic [DW-1:0]   seed,
    input  logic [AW-1:0]   base_addr,
    input  logic [NBW-1:0]  num_bursts,
    input  logic [BLW-1:0]  burst_len,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            busy,
    output logic            done,
    output logic [15:0]     err_cnt,
    output logic [AW-1:0]   first_err_addr,
    output logic            timeout
);
    localparam int BYTES = DW / 8;
    localparam int TW    = $clog2(TMO + 1);
    localparam logic [AW-1:0] AMASK = ~AW'(BYTES - 1);
    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_END = 3'b111;
    localparam logic [DW-1:0] TAPS =
        (DW == 16) ? DW'(16'hB400) :
        (DW == 32) ? DW'(32'h8020_0003) :
        (DW == 64) ? DW'(64'hD800_0000_0000_0000) :
                     {1'b1, {(DW-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WGAP, S_GAP, S_RD, S_RGAP, S_DONE} state_t;

    state_t          r_state;
    logic            r_mode;
    logic [DW-1:0]   r_seed;
    logic [AW-1:0]   r_base;
    logic [BLW-1:0]  r_blen;
    logic [NBW-1:0]  r_nb;
    logic [BLW-1:0]  r_beat;   // beats remaining after the current one
    logic [NBW-1:0]  r_burst;  // bursts remaining after the current one
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_lfsr;
    logic            r_cyc;
    logic            r_we;
    logic [2:0]      r_cti;
    logic [TW-1:0]   r_tmo;
    logic [15:0]     r_err;
    logic [AW-1:0]   r_first;
    logic            r_timeout;

    logic [DW-1:0]   w_exp;
    logic [DW-1:0]   w_lfsr_nx;
    logic            w_ack;
    logic [BLW-1:0]  w_blen_in;

    function automatic logic [DW-1:0] f_lfsr_init(input logic [DW-1:0] s);
        return (s == '0) ? DW'(1) : s;
    endfunction

    assign w_exp     = r_mode ? r_lfsr : (DW'(r_addr) ^ r_seed);
    assign w_lfsr_nx = {1'b0, r_lfsr[DW-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
    assign w_ack     = r_cyc & wb_ack_i;
    assign w_blen_in = (burst_len == '0) ? BLW'(1) : burst_len;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_seed    <= '0;
            r_base    <= '0;
            r_blen    <= '0;
            r_nb      <= '0;
            r_beat    <= '0;
            r_burst   <= '0;
            r_addr    <= '0;
            r_lfsr    <= '0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_cti     <= '0;
            r_tmo     <= '0;
            r_err     <= '0;
            r_first   <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (start) begin
                        r_mode    <= mode;
                        r_seed    <= seed;
                        r_base    <= base_addr & AMASK;
                        r_blen    <= w_blen_in;
                        r_nb      <= num_bursts;
                        r_err     <= '0;
                        r_first   <= '0;
                        r_timeout <= 1'b0;
                        if (num_bursts == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WR;
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b1;
                            r_addr  <= base_addr & AMASK;
                            r_lfsr  <= f_lfsr_init(seed);
                            r_beat  <= w_blen_in - 1'b1;
                            r_burst <= num_bursts - 1'b1;
                            r_cti   <= (w_blen_in == BLW'(1)) ? CTI_END : CTI_INC;
                        end
                    end
                end
                S_WR, S_RD: begin
                    if (w_ack) begin
                        r_tmo  <= '0;
                        r_addr <= r_addr + AW'(BYTES);
                        r_lfsr <= w_lfsr_nx;
                        if (r_state == S_RD && wb_dat_i != w_exp) begin
                            if (r_err == '0)      r_first <= r_addr;
                            if (r_err != 16'hFFFF) r_err  <= r_err + 16'd1;
                        end
                        if (r_beat == '0) begin
                            r_cyc <= 1'b0;
                            r_cti <= '0;
                            if (r_burst == '0) begin
                                r_state <= (r_state == S_WR) ? S_GAP : S_DONE;
                            end else begin
                                r_burst <= r_burst - 1'b1;
                                r_state <= (r_state == S_WR) ? S_WGAP : S_RGAP;
                            end
                        end else begin
                            r_beat <= r_beat - 1'b1;
                            r_cti  <= (r_beat == BLW'(1)) ? CTI_END : CTI_INC;
                        end
                    end else if (r_tmo == TW'(TMO - 1)) begin
                        // Slave went silent: abandon the test rather than hang the bus.
                        r_cyc     <= 1'b0;
                        r_we      <= 1'b0;
                        r_cti     <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WGAP, S_RGAP: begin
                    r_tmo   <= '0;
                    r_cyc   <= 1'b1;
                    r_beat  <= r_blen - 1'b1;
                    r_cti   <= (r_blen == BLW'(1)) ? CTI_END : CTI_INC;
                    r_state <= (r_state == S_WGAP) ? S_WR : S_RD;
                end
                S_GAP: begin
                    // Read phase replays the same address walk and pattern sequence.
                    r_tmo   <= '0;
                    r_cyc   <= 1'b1;
                    r_we    <= 1'b0;
                    r_addr  <= r_base;
                    r_lfsr  <= f_lfsr_init(r_seed);
                    r_beat  <= r_blen - 1'b1;
                    r_burst <= r_nb - 1'b1;
                    r_cti   <= (r_blen == BLW'(1)) ? CTI_END : CTI_INC;
                    r_state <= S_RD;
                end
                S_DONE: begin
                    r_tmo   <= '0;
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wb_cyc_o       = r_cyc;
    assign wb_stb_o       = r_cyc;
    assign wb_we_o        = r_cyc & r_we;
    assign wb_addr_o      = r_addr;
    assign wb_dat_o       = (r_cyc && r_we) ? w_exp : '0;
    assign wb_sel_o       = '1;
    assign wb_cti_o       = r_cti;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign err_cnt        = r_err;
    assign first_err_addr = r_first;
    assign timeout        = r_timeout;
endmodule

// File: tb/tb_wb_burst_traffic_checker.sv
// Directed bench: table of test configurations with hand-computed results, a
// memory-backed slave, and a bus monitor checking address, cti and write data.
module tb_wb_burst_traffic_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] seed;
    logic [31:0] base;
    logic [15:0] nb;
    logic [4:0]  bl;
    logic        cyc, stb, we, ack, busy, done, tmo_o;
    logic [31:0] addr, dat_o, dat_i, first;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [15:0] err;

    wb_burst_traffic_checker dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .mode(mode), .seed(seed),
        .base_addr(base), .num_bursts(nb), .burst_len(bl),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr),
        .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_cti_o(cti), .wb_ack_i(ack),
        .wb_dat_i(dat_i), .busy(busy), .done(done), .err_cnt(err),
        .first_err_addr(first), .timeout(tmo_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: zero-wait acks, memory readback, optional bit0 corruption at one address.
    logic        noack = 1'b0;
    logic        corrupt = 1'b0;
    logic [31:0] corrupt_addr = 32'h108;
    logic [31:0] mem [0:255];
    assign ack   = cyc & stb & ~noack;
    assign dat_i = mem[addr[9:2]] ^ ((corrupt && addr == corrupt_addr) ? 32'h1 : 32'h0);

    typedef struct {
        logic        mode;
        logic [31:0] seed;
        logic [31:0] base;
        logic [15:0] nb;
        logic [4:0]  bl;
        logic        corrupt;
        logic        noack;
        int          beats;
        logic [15:0] err;
        logic [31:0] first;
        logic        to;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs[8];

    // Bus monitor state
    logic        mon_en = 1'b0;
    logic        mon_wr;
    logic        mon_mode;
    logic [31:0] mon_base, mon_addr, mon_seed;
    logic [31:0] mon_d[2];
    int          mon_bl, mon_k, beats, wcnt, stb_cycles;
    logic        gap_chk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (gap_chk) begin
                chk("gap_cyc", cyc, 0);
                gap_chk = 1'b0;
            end
            if (cyc && stb) stb_cycles++;
            if (cyc && stb && ack) begin
                if (we != mon_wr) begin
                    mon_wr   = we;
                    mon_addr = mon_base;
                    mon_k    = 0;
                end
                chk("addr", addr, mon_addr);
                chk("cti", cti, (mon_k == mon_bl - 1) ? 3'b111 : 3'b010);
                chk("sel", sel, 4'hF);
                if (we) begin
                    mem[addr[9:2]] = dat_o;
                    if (wcnt < 2) chk("wdat", dat_o, mon_d[wcnt]);
                    if (!mon_mode) chk("wpat", dat_o, addr ^ mon_seed);
                    wcnt++;
                end
                beats++;
                mon_addr = mon_addr + 32'd4;
                if (mon_k == mon_bl - 1) begin
                    mon_k   = 0;
                    gap_chk = 1'b1;
                end else begin
                    mon_k++;
                end
            end
        end
    end

    task automatic setup(input vec_t v);
        mode = v.mode; seed = v.seed; base = v.base; nb = v.nb; bl = v.bl;
        corrupt = v.corrupt; noack = v.noack;
        mon_wr = 1'b1; mon_mode = v.mode; mon_base = v.base; mon_addr = v.base;
        mon_seed = v.seed; mon_d[0] = v.d0; mon_d[1] = v.d1;
        mon_bl = (v.bl == 0) ? 1 : int'(v.bl);
        mon_k = 0; beats = 0; wcnt = 0; stb_cycles = 0; gap_chk = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit start_at_done, input string tag);
        bit got;
        setup(v);
        mon_en = 1'b1;
        pulse_start();
        chk({tag, "_busy1"}, busy, 1);
        if (v.nb != 0) chk({tag, "_cyc1"}, cyc, 1);
        else           chk({tag, "_done1"}, done, 1);
        got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s_done_wait: no done within 3000 cycles", tag);
        end
        if (start_at_done) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_end"}, busy, 0);
        if (start_at_done) begin
            @(posedge clk); #1;
            chk({tag, "_ign_busy"}, busy, 0);
            chk({tag, "_ign_cyc"}, cyc, 0);
        end
        mon_en = 1'b0;
        chk({tag, "_beats"}, beats, v.beats);
        chk({tag, "_err"}, err, v.err);
        if (v.err != 0) chk({tag, "_first"}, first, v.first);
        chk({tag, "_timeout"}, tmo_o, v.to);
        if (v.noack) chk({tag, "_stb_cycles"}, stb_cycles, 255);
        noack = 1'b0; corrupt = 1'b0;
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        //          mode seed          base          nb    bl  cor noack beats err first   to  d0            d1
        vecs[0] = '{1'b0, 32'h0,      32'h100,      16'd2, 5'd4, 0, 0, 16, 16'd0, 32'h0,   0, 32'h100,      32'h104};
        vecs[1] = '{1'b0, 32'h0,      32'h100,      16'd2, 5'd4, 1, 0, 16, 16'd1, 32'h108, 0, 32'h100,      32'h104};
        vecs[2] = '{1'b1, 32'h0,      32'h100,      16'd2, 5'd4, 0, 0, 16, 16'd0, 32'h0,   0, 32'h1,        32'h8020_0003};
        vecs[3] = '{1'b0, 32'h0,      32'h100,      16'd2, 5'd4, 0, 1, 0,  16'd0, 32'h0,   1, 32'h0,        32'h0};
        vecs[4] = '{1'b0, 32'h0,      32'hFFFF_FFF8, 16'd1, 5'd4, 0, 0, 8,  16'd0, 32'h0,   0, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        vecs[5] = '{1'b0, 32'h0,      32'h100,      16'd0, 5'd4, 0, 0, 0,  16'd0, 32'h0,   0, 32'h0,        32'h0};
        vecs[6] = '{1'b0, 32'hA5A5,   32'h40,       16'd3, 5'd0, 0, 0, 6,  16'd0, 32'h0,   0, 32'hA5E5,     32'hA5E1};
        vecs[7] = '{1'b1, 32'h1234,   32'h200,      16'd1, 5'd3, 0, 0, 6,  16'd0, 32'h0,   0, 32'h1234,     32'h91A};

        rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; base = '0; nb = '0; bl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_cti", cti, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_first", first, 0);
        chk("rst_timeout", tmo_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0, $sformatf("v%0d", i));

        // Start during the DONE cycle must be dropped.
        run_vec(vecs[0], 1'b1, "start_at_done");

        // Start while busy is ignored; reset mid-read kills the bus with no done.
        setup(vecs[0]);
        pulse_start();
        base = 32'h500;
        pulse_start();
        base = 32'h100;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cyc && !we) begin got = 1'b1; break; end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL midrd_wait: read phase never reached");
        end
        chk("busy_start_ignored_addr", addr, 32'h100);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrd_cyc", cyc, 0);
        chk("midrd_stb", stb, 0);
        chk("midrd_addr", addr, 0);
        chk("midrd_busy", busy, 0);
        chk("midrd_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
